// File: rtl/zprize_msm_pkg.sv
// Shared definitions for the MSM datapath: flow-control FSM states and the
// multiplier sideband layout (valid flag in bit 0, user data above it).
package zprize_msm_pkg;

  typedef enum logic [0:0] {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } flow_state_e;

  localparam int SB_VLD_BIT  = 0;
  localparam int SB_USER_LSB = 1;

endpackage

// File: rtl/zprize_mul_res_fifo.sv
// Show-ahead result FIFO; head entry reads as zero while empty, and a write
// into a full FIFO without a same-cycle pop is dropped and flagged on ovf.
module zprize_mul_res_fifo #(
  parameter int WD    = 800,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [WD-1:0] wr_data,
  input  logic          rd_en,
  output logic [WD-1:0] rd_data,
  output logic          empty,
  output logic          ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WD-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_rd;
  logic          do_wr;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign do_rd = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a write at full is still legal.
  assign do_wr = wr_en & (~full | do_rd);
  assign ovf   = wr_en & full & ~do_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/zprize_mul_flow_ctrl.sv
// Credit-based flow control around a fixed-latency multiplier with a result FIFO.
// Define ZPRIZE_MUL_FLOW_PERF_EN to build the issue/stall performance counters.
module zprize_mul_flow_ctrl
  import zprize_msm_pkg::*;
#(
  parameter int W     = 384,
  parameter int M     = 32,
  parameter int LAT   = 9,
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_a,
  input  logic [W-1:0]   s_b,
  input  logic [M-2:0]   s_user,
  output logic [W-1:0]   mul_in0,
  output logic [W-1:0]   mul_in1,
  output logic [M-1:0]   mul_m_i,
  input  logic [2*W-1:0] mul_out0,
  input  logic [M-1:0]   mul_m_o,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [2*W-1:0] m_prod,
  output logic [M-2:0]   m_user,
  output logic           err_ovf,
  output logic [31:0]    perf_issue_cnt,
  output logic [31:0]    perf_stall_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(LAT + 1);
  localparam int WD = 2*W + M - 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(LAT - 1);

  flow_state_e   state;
  logic [FW-1:0] flush_cnt;
  logic [CW-1:0] credit;
  logic          hs;
  logic          pop;
  logic          fifo_wr;
  logic          fifo_empty;
  logic          fifo_ovf;
  logic [WD-1:0] fifo_rd_data;

  logic [W-1:0]  a_p0;
  logic [W-1:0]  b_p0;
  logic [M-2:0]  user_p0;
  logic          vld_p0;

  assign s_ready = (state == RUN) && (credit != '0);
  assign hs      = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  // FLUSH holds off issue for LAT cycles so the unreset sideband pipe drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FLUSH;
      flush_cnt <= '0;
    end else if (state == FLUSH) begin
      if (flush_cnt == FLUSH_LAST) state <= RUN;
      else                         flush_cnt <= flush_cnt + FW'(1);
    end
  end

  // Credits cover both in-flight products and FIFO occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= CREDIT_MAX;
    end else begin
      case ({hs, pop})
        2'b10:   credit <= credit - CW'(1);
        2'b01:   credit <= credit + CW'(1);
        default: credit <= credit;
      endcase
    end
  end

  // ---- stage p0: registered issue to the multiplier ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p0    <= '0;
      b_p0    <= '0;
      user_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= hs;
      if (hs) begin
        a_p0    <= s_a;
        b_p0    <= s_b;
        user_p0 <= s_user;
      end
    end
  end

  assign mul_in0 = a_p0;
  assign mul_in1 = b_p0;
  assign mul_m_i = {user_p0, vld_p0};

  // ---- multiplier return: capture into the result FIFO ----
  assign fifo_wr = (state == RUN) & mul_m_o[SB_VLD_BIT];

  zprize_mul_res_fifo #(
    .WD    (WD),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data ({mul_out0, mul_m_o[M-1:SB_USER_LSB]}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .ovf     (fifo_ovf)
  );

  assign m_valid = ~fifo_empty;
  assign m_prod  = fifo_rd_data[WD-1 -: 2*W];
  assign m_user  = fifo_rd_data[M-2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           err_ovf <= 1'b0;
    else if (fifo_ovf) err_ovf <= 1'b1;
  end

`ifdef ZPRIZE_MUL_FLOW_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (hs) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if ((state == RUN) && s_valid && !s_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  assign perf_issue_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_zprize_mul_flow_ctrl.sv
// Bench for zprize_mul_flow_ctrl: LAT-cycle multiplier model with an unreset
// sideband pipe, a queue-based flow model checked every cycle, and directed cases.
module tb_zprize_mul_flow_ctrl;

  localparam int W     = 384;
  localparam int M     = 32;
  localparam int LAT   = 9;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_valid;
  logic           s_ready;
  logic [W-1:0]   s_a;
  logic [W-1:0]   s_b;
  logic [M-2:0]   s_user;
  logic [W-1:0]   mul_in0;
  logic [W-1:0]   mul_in1;
  logic [M-1:0]   mul_m_i;
  logic [2*W-1:0] mul_out0;
  logic [M-1:0]   mul_m_o;
  logic           m_valid;
  logic           m_ready;
  logic [2*W-1:0] m_prod;
  logic [M-2:0]   m_user;
  logic           err_ovf;
  logic [31:0]    perf_issue_cnt;
  logic [31:0]    perf_stall_cnt;

  always #5 clk = ~clk;

  zprize_mul_flow_ctrl #(.W(W), .M(M), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_user(s_user),
    .mul_in0(mul_in0), .mul_in1(mul_in1), .mul_m_i(mul_m_i),
    .mul_out0(mul_out0), .mul_m_o(mul_m_o),
    .m_valid(m_valid), .m_ready(m_ready), .m_prod(m_prod), .m_user(m_user),
    .err_ovf(err_ovf), .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  // Multiplier model: unreset pipe, latency selectable, plus a valid injector.
  logic [2*W-1:0] pipe_p [16];
  logic [M-1:0]   pipe_m [16];
  int             mlat = LAT;
  logic           inj  = 1'b0;

  always @(posedge clk) begin
    for (int i = 15; i > 0; i--) begin
      pipe_p[i] <= pipe_p[i-1];
      pipe_m[i] <= pipe_m[i-1];
    end
    pipe_p[0] <= {{W{1'b0}}, mul_in0} * {{W{1'b0}}, mul_in1};
    pipe_m[0] <= mul_m_i;
  end

  assign mul_out0 = pipe_p[mlat-1];
  assign mul_m_o  = pipe_m[mlat-1] | {{(M-1){1'b0}}, inj};

  // Flow model: every accepted op is owed back in order, LAT+2 cycles later.
  typedef struct {
    logic [2*W-1:0] prod;
    logic [M-2:0]   user;
    int             rdy;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   rel_cnt = 0;
  int   n_issue = 0;
  int   n_stall = 0;
  logic ovf_exp = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  function automatic logic model_run();
    return rel_cnt >= LAT;
  endfunction

  function automatic logic model_sready();
    return model_run() && (q.size() < DEPTH);
  endfunction

  function automatic logic model_mvalid();
    return (q.size() > 0) && (q[0].rdy <= cyc);
  endfunction

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    logic sr;
    logic mv;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        rel_cnt = 0;
        n_issue = 0;
        n_stall = 0;
      end else begin
        sr = model_sready();
        mv = model_mvalid();
        if (mv && m_ready) void'(q.pop_front());
        if (s_valid && sr) begin
          e.prod = {{W{1'b0}}, s_a} * {{W{1'b0}}, s_b};
          e.user = s_user;
          e.rdy  = cyc + mlat + 2;
          q.push_back(e);
          n_issue++;
        end
        if (model_run() && s_valid && !sr) n_stall++;
        rel_cnt++;
      end
      cyc++;
    end
  end

  initial begin
    logic [31:0] exp_iss;
    logic [31:0] exp_stl;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_mul_m_i", mul_m_i, 0);
        chk("rst_mul_in0", mul_in0, 0);
        chk("rst_mul_in1", mul_in1, 0);
        chk("rst_m_prod", m_prod, 0);
        chk("rst_m_user", m_user, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_perf_issue", perf_issue_cnt, 0);
        chk("rst_perf_stall", perf_stall_cnt, 0);
      end else begin
`ifdef ZPRIZE_MUL_FLOW_PERF_EN
        exp_iss = n_issue;
        exp_stl = n_stall;
`else
        exp_iss = 0;
        exp_stl = 0;
`endif
        chk("s_ready", s_ready, model_sready());
        chk("m_valid", m_valid, model_mvalid());
        if (model_mvalid() && m_valid) begin
          chk("m_prod", m_prod, q[0].prod);
          chk("m_user", m_user, q[0].user);
        end
        chk("err_ovf", err_ovf, ovf_exp);
        chk("perf_issue", perf_issue_cnt, exp_iss);
        chk("perf_stall", perf_stall_cnt, exp_stl);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [M-2:0] u,
                       output int t_issue);
    @(posedge clk);
    #2;
    s_valid = 1'b1; s_a = a; s_b = b; s_user = u;
    t_issue = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_ready) begin
        t_issue = cyc;
        break;
      end
    end
    if (t_issue < 0) chk("issue_timeout", 0, 1);
    @(posedge clk);
    #2;
    s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (m_valid) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic burst(input int n, output int acc);
    acc = 0;
    @(posedge clk);
    for (int i = 0; i < n; i++) begin
      #2;
      s_valid = 1'b1; s_a = W'(acc + 1); s_b = W'(acc + 100); s_user = (M-1)'(acc);
      @(negedge clk);
      if (s_ready) acc++;
      @(posedge clk);
    end
    #2;
    s_valid = 1'b0;
  endtask

  task automatic drain16();
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("drain_valid", m_valid, 1);
      chk("drain_user", m_user, k);
      chk("drain_prod", m_prod, (k + 1) * (k + 100));
      if (k == 0) chk("s_ready_at_first_pop", s_ready, 0);
      if (k == 1) chk("s_ready_after_first_pop", s_ready, 1);
    end
    @(negedge clk);
    chk("drain_empty", m_valid, 0);
  endtask

  initial begin
    int t0;
    int at;
    int n0;
    int acc;
    int stale;
    logic [2*W-1:0] big;
    rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_user = '0; m_ready = 1'b1;
    repeat (12) @(posedge clk);

    // Release with a request pending: nine not-ready cycles, then 3*5 with user 0x1234.
    #2;
    rst = 1'b0; s_valid = 1'b1; s_a = W'(3); s_b = W'(5); s_user = 31'h1234;
    n0 = 0; t0 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_ready) begin
        t0 = cyc;
        break;
      end
      n0++;
    end
    chk("flush_not_ready_cycles", n0, 9);
    @(posedge clk);
    #2;
    s_valid = 1'b0;
    wait_mvalid(at);
    chk("first_latency", at - t0, 11);
    chk("first_prod", m_prod, 15);
    chk("first_user", m_user, 31'h1234);

    // All-ones operands.
    issue('1, '1, 31'h7, t0);
    wait_mvalid(at);
    big = {{383{1'b1}}, {384{1'b0}}, 1'b1};
    chk("max_prod", m_prod, big);
    chk("max_latency", at - t0, 11);

    // Backpressure: 20 requests against a stalled sink, then drain in order.
    @(posedge clk);
    #2;
    m_ready = 1'b0;
    burst(20, acc);
    chk("bp_accepted", acc, 16);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("bp_s_ready_low", s_ready, 0);
    chk("bp_no_ovf", err_ovf, 0);
    drain16();

    // Reset with five ops in flight: nothing stale may surface.
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      #2;
      s_valid = 1'b1; s_a = W'(i + 11); s_b = W'(i + 21); s_user = (M-1)'(i + 300);
      @(posedge clk);
    end
    #2;
    s_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_valid) stale++;
    end
    chk("no_stale_after_reset", stale, 0);
    issue(W'(7), W'(6), 31'h55, t0);
    wait_mvalid(at);
    chk("post_reset_prod", m_prod, 42);
    chk("post_reset_user", m_user, 31'h55);
    chk("post_reset_latency", at - t0, 11);

    // Shorter multiplier latency, full FIFO, then an extra injected return.
    repeat (20) @(posedge clk);
    #2;
    mlat = 7; m_ready = 1'b0;
    burst(16, acc);
    chk("ovf_case_accepted", acc, 16);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("full_no_ovf", err_ovf, 0);
    chk("full_m_valid", m_valid, 1);
    @(posedge clk);
    #2;
    inj = 1'b1;
    @(posedge clk);
    #2;
    inj = 1'b0; ovf_exp = 1'b1;
    @(negedge clk);
    chk("ovf_set", err_ovf, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("ovf_sticky", err_ovf, 1);
    drain16();
    chk("ovf_sticky_after_drain", err_ovf, 1);

    @(posedge clk);
    #2;
    rst = 1'b1; ovf_exp = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("ovf_cleared_by_reset", err_ovf, 0);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zprize_mul_flow_ctrl.md
ZPRIZE_MUL_FLOW_CTRL -- requirements
Module: zprize_mul_flow_ctrl

Interface
REQ-001 SHALL have parameter W, default 384: operand width; the product width is 2W.
REQ-002 SHALL have parameter M, default 32: multiplier sideband width; bit 0 is the valid flag and bits M-1:1 are user data.
REQ-003 SHALL have parameter LAT, default 9: fixed in0-to-out0 latency of the attached multiplier, in cycles.
REQ-004 SHALL have parameter DEPTH, default 16: result FIFO entries; power of two, >= LAT+2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have ports s_valid (input, 1), s_ready (output, 1), s_a (input, W), s_b (input, W), s_user (input, M-1): the upstream operand channel.
REQ-008 SHALL have ports mul_in0 (output, W), mul_in1 (output, W), mul_m_i (output, M): the multiplier issue side.
REQ-009 SHALL have ports mul_out0 (input, 2W), mul_m_o (input, M): the multiplier return side.
REQ-010 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_prod (output, 2W), m_user (output, M-1): the downstream product channel.
REQ-011 SHALL have port err_ovf, output, 1 bit: sticky flag, set on a write into a full FIFO.
REQ-012 SHALL have ports perf_issue_cnt and perf_stall_cnt, output, 32 bits each: performance counters.

Function
REQ-013 SHALL use an FSM with states FLUSH and RUN; reset enters FLUSH, and FLUSH moves to RUN after exactly LAT cycles counted by a flush counter.
- In FLUSH: s_ready=0, mul_m_i[0]=0, and mul_m_o returns are ignored.
REQ-014 SHALL hold a credit counter, range 0..DEPTH, reset value DEPTH.
- Decrements on each accepted handshake (s_valid & s_ready).
- Increments on each pop (m_valid & m_ready).
- Unchanged when a handshake and a pop occur in the same cycle.
REQ-015 SHALL drive s_ready = (state==RUN) & (credit!=0), decoded from registers only, with no combinational path from m_ready; credit freed by a pop makes s_ready rise on the next cycle.
REQ-016 SHALL register operands on a handshake:
- Next cycle: mul_in0=s_a, mul_in1=s_b, mul_m_i={s_user,1'b1}.
- On cycles without a handshake: mul_m_i[0]=0 and mul_in0/mul_in1 hold their last values.
REQ-017 SHALL write {mul_out0, mul_m_o[M-1:1]} into the FIFO on every RUN cycle with mul_m_o[0]=1.
REQ-018 SHALL implement the FIFO as a show-ahead FIFO:
- m_valid = !empty.
- m_prod/m_user present the head entry.
- Outputs stay stable while m_valid & !m_ready.
REQ-019 SHALL give handshake-to-m_valid latency of exactly LAT+2 cycles when the FIFO is empty.
REQ-020 SHALL deliver products in issue order.
REQ-021 SHALL wrap the FIFO read and write pointers modulo DEPTH.
- A simultaneous write and pop at full or at empty is legal; occupancy is unchanged.
REQ-022 SHALL drop the write and set err_ovf when a write arrives with the FIFO full and no pop in the same cycle; err_ovf is cleared only by reset.

Reset
REQ-023 SHALL, while rst=1, immediately force the following:
- state=FLUSH, flush count=0, credit=DEPTH.
- FIFO empty, so m_valid=0; s_ready=0; mul_m_i=0.
- err_ovf=0; both perf counters=0.
- mul_in0, mul_in1, m_prod and m_user all zero.
REQ-024 SHALL, on reset asserted mid-operation, discard all in-flight and queued products.
- The non-reset sideband pipeline of the multiplier is neutralised by the LAT-cycle FLUSH.
- No pre-reset product ever appears on m_valid.

Configuration
REQ-025 SHALL, with macro ZPRIZE_MUL_FLOW_PERF_EN defined, count as follows:
- perf_issue_cnt counts handshakes.
- perf_stall_cnt counts RUN cycles with s_valid & !s_ready.
- Both wrap at 2^32.
REQ-026 SHALL, without ZPRIZE_MUL_FLOW_PERF_EN, keep both perf ports present and tie them to constant zero, with no counter flops.

Structure
REQ-027 SHALL place the FSM state enum and the sideband field constants (valid bit index 0; user field M-1:1) in the shared package zprize_msm_pkg.
REQ-028 SHALL implement the FIFO as sub-module zprize_mul_res_fifo, with parameters WD=2W+M-1 and DEPTH.

Verification (W=384, M=32, LAT=9, DEPTH=16; behavioural LAT-cycle multiplier model with an unreset sideband pipe)
REQ-029 SHALL check: rst released, s_valid=1 -> s_ready=0 for 9 cycles, then 1.
REQ-030 SHALL check: a=3, b=5, user=0x1234 accepted at cycle t -> m_valid=1 at t+11 with m_prod=15 and m_user=0x1234.
REQ-031 SHALL check: a=b=2^384-1 -> m_prod=2^768-2^385+1.
REQ-032 SHALL check backpressure and drain:
- m_ready=0 with 20 requests: exactly 16 accepted, s_ready=0 thereafter, err_ovf=0.
- Then m_ready=1: 16 products drain in order and s_ready returns 1 a cycle after the first pop.
REQ-033 SHALL check: 5 ops in flight, rst pulsed for 1 cycle -> m_valid stays 0, no stale product ever emerges, and a new op after FLUSH returns the correct value.
REQ-034 SHALL check: the model's LAT forced to 7 and 16 ops queued at m_ready=0 -> no err_ovf; the model injects an extra valid return -> err_ovf=1, and it stays set.
